key_autorepeat: RTL and testbench
=================================

// Module: key_autorepeat
// PURPOSE
//   Upstream key conditioner for the lab counter path. Synchronises one raw
//   active-low board key and debounces it. Emits one-cycle press and release
//   strobes, plus periodic auto-repeat strobes while the key is held.
//   press_o drives the count/latch enable of the downstream counter and
//   register stages.
// PARAMETERS
//   DEBOUNCE_CYCLES      2_000_000   consecutive stable cycles to accept a new key level (20 ms @ 100 MHz)
//   REPEAT_DELAY_CYCLES  50_000_000  held cycles from accepted press to first repeat (500 ms)
//   REPEAT_PERIOD_CYCLES 10_000_000  cycles between subsequent repeats (100 ms)
//   All parameters are >= 2. Timer widths are $clog2 of the largest value + 1.
// PORTS
//   clk100_i     in   1  system clock, 100 MHz
//   rstn_i       in   1  asynchronous reset, active-low
//   key_i        in   1  raw key, active-low (0 = pressed), asynchronous to clk100_i
//   repeat_en_i  in   1  1 = auto-repeat enabled; sampled every cycle
//   held_o       out  1  debounced level, 1 = key held
//   press_o      out  1  1-cycle strobe on accepted press and on every repeat
//   repeat_o     out  1  1-cycle strobe on repeats only (subset of press_o)
//   release_o    out  1  1-cycle strobe on accepted release
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - Synchroniser flops = 1; debounced level = released; FSM = IDLE; timers = 0.
//   - All outputs = 0.
//   Synchroniser: 2 flops on key_i; the debouncer sees only the 2nd flop output (ks).
//   Debounce:
//   - Counter increments every cycle where ks != debounced level.
//   - Counter clears on any cycle where ks == debounced level.
//   - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the
//     counter clears.
//   - A glitch shorter than DEBOUNCE_CYCLES produces no output activity.
//   Latency: key_i low first sampled at edge E0 and held low. held_o and press_o
//     rise at edge E0+DEBOUNCE_CYCLES+2. press_o stays high exactly 1 cycle.
//     Release latency is symmetric: release_o pulses and held_o falls.
//   FSM:
//   - IDLE: held_o=0.
//     -> HOLD on accepted press; pulse press_o; repeat timer = 0.
//   - HOLD: timer increments while repeat_en_i=1 and holds at 0 while repeat_en_i=0.
//     -> REPEAT when timer reaches REPEAT_DELAY_CYCLES; pulse press_o + repeat_o;
//        timer = 0.
//   - REPEAT: timer increments while repeat_en_i=1.
//     On reaching REPEAT_PERIOD_CYCLES: pulse press_o + repeat_o; timer = 0.
//     repeat_en_i=0 -> back to HOLD with timer = 0, so the full delay restarts.
//   - HOLD/REPEAT -> IDLE on accepted release; pulse release_o; timer = 0.
//   Simultaneous events:
//   - Release wins over a due repeat in the same cycle: release_o=1, press_o=0, repeat_o=0.
//   - press_o and release_o are never high together.
//   - At most one press_o strobe per cycle.
//   Key already low when rstn_i deasserts: treated as a fresh press after
//     DEBOUNCE_CYCLES+2 cycles.
//   Reset mid-operation: outputs drop to 0 immediately (async).
//     No release_o is generated for the aborted hold.
//   Timers saturate-free; wrap is impossible because each compares and clears at
//     its terminal value.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3)
//   1 key_i low 3 cycles then high -> no press_o/release_o/held_o activity.
//   2 key_i low held from edge E0, repeat_en_i=0 -> press_o single pulse at E0+6;
//     held_o=1; no repeat_o for 50 cycles.
//   3 As 2 with repeat_en_i=1 -> repeat_o/press_o at E0+16, E0+19, E0+22, ...;
//     release -> release_o 6 cycles after first high sample; repeats stop.
//   4 Release accepted on the same cycle a repeat is due -> release_o=1,
//     press_o=0, repeat_o=0; FSM returns to IDLE.
//   5 rstn_i low mid-REPEAT -> all outputs 0 same cycle.
//     Key still low at rstn_i release -> press_o 6 cycles later.
//   6 repeat_en_i dropped for 1 cycle in REPEAT -> next repeat_o arrives a full
//     10 cycles after re-enable.

Source files
------------

// File: rtl/key_autorepeat_if.sv
// Key conditioner signal bundle: raw key and repeat enable in, debounced
// level and one-cycle strobes out.
interface key_autorepeat_if;
  logic key_i;
  logic repeat_en_i;
  logic held_o;
  logic press_o;
  logic repeat_o;
  logic release_o;

  modport master (
    output key_i,
    output repeat_en_i,
    input  held_o,
    input  press_o,
    input  repeat_o,
    input  release_o
  );

  modport slave (
    input  key_i,
    input  repeat_en_i,
    output held_o,
    output press_o,
    output repeat_o,
    output release_o
  );
endinterface

// File: rtl/key_autorepeat.sv
// Synchronises and debounces one active-low key, then emits press, release
// and auto-repeat strobes for the downstream counter path.
module key_autorepeat #(
  parameter int DEBOUNCE_CYCLES      = 2_000_000,
  parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 10_000_000
) (
  input logic             clk100_i,
  input logic             rstn_i,
  key_autorepeat_if.slave kbd
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  logic [1:0]       sync_q;
  logic             ks;
  logic             mismatch;
  logic             db_done;
  logic             accept_press;
  logic             accept_release;
  logic [DB_W-1:0]  db_cnt_q;
  logic             held_q;

  state_t           state_q, state_n;
  logic [RPT_W-1:0] rpt_tmr_q, rpt_tmr_n;
  logic             press_q, press_n;
  logic             repeat_q, repeat_n;
  logic             release_q, release_n;

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], kbd.key_i};
    end
  end

  assign ks       = sync_q[1];
  assign mismatch = (~ks) != held_q;
  assign db_done  = mismatch && (db_cnt_q == DB_LAST);

  assign accept_press   = db_done && !held_q;
  assign accept_release = db_done && held_q;

  // The level flips one cycle after the count has reached its terminal value,
  // which is what puts the accepted edge DEBOUNCE_CYCLES+2 after first sample.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      db_cnt_q <= '0;
      held_q   <= 1'b0;
    end else if (!mismatch) begin
      db_cnt_q <= '0;
    end else if (db_done) begin
      db_cnt_q <= '0;
      held_q   <= ~held_q;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      rpt_tmr_q <= '0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      rpt_tmr_q <= rpt_tmr_n;
      press_q   <= press_n;
      repeat_q  <= repeat_n;
      release_q <= release_n;
    end
  end

  // Release is checked first in both held states so it always beats a repeat
  // falling due on the same cycle.
  always_comb begin
    state_n   = state_q;
    rpt_tmr_n = rpt_tmr_q;
    press_n   = 1'b0;
    repeat_n  = 1'b0;
    release_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rpt_tmr_n = '0;
        if (accept_press) begin
          state_n = ST_HOLD;
          press_n = 1'b1;
        end
      end

      ST_HOLD: begin
        if (accept_release) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
          rpt_tmr_n = '0;
        end else if (!kbd.repeat_en_i) begin
          rpt_tmr_n = '0;
        end else if (rpt_tmr_q == DELAY_LAST) begin
          state_n   = ST_REPEAT;
          press_n   = 1'b1;
          repeat_n  = 1'b1;
          rpt_tmr_n = '0;
        end else begin
          rpt_tmr_n = rpt_tmr_q + RPT_W'(1);
        end
      end

      ST_REPEAT: begin
        if (accept_release) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
          rpt_tmr_n = '0;
        end else if (!kbd.repeat_en_i) begin
          state_n   = ST_HOLD;
          rpt_tmr_n = '0;
        end else if (rpt_tmr_q == PERIOD_LAST) begin
          press_n   = 1'b1;
          repeat_n  = 1'b1;
          rpt_tmr_n = '0;
        end else begin
          rpt_tmr_n = rpt_tmr_q + RPT_W'(1);
        end
      end

      default: begin
        state_n   = ST_IDLE;
        rpt_tmr_n = '0;
      end
    endcase
  end

  assign kbd.held_o    = held_q;
  assign kbd.press_o   = press_q;
  assign kbd.repeat_o  = repeat_q;
  assign kbd.release_o = release_q;

endmodule

// File: tb/tb_key_autorepeat.sv
// Bench for key_autorepeat with short timing parameters: a scenario table plus
// hand-built reset and repeat-enable sequences, checked through a strobe scoreboard.
module tb_key_autorepeat;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  typedef struct {
    int cyc;
    bit press;
    bit rpt;
    bit rel;
  } ev_t;

  typedef struct {
    int low_len;
    bit rep_en;
    bit exp_pressed;
    int exp_repeats;
  } vec_t;

  logic clk100_i = 1'b0;
  logic rstn_i;
  int   cyc = 0;
  int   vectors_applied = 0;
  int   miscompares = 0;
  int   rep_seen = 0;
  ev_t  exp_q[$];
  ev_t  mon_ev;
  vec_t vecs[8];

  key_autorepeat_if kbd();

  key_autorepeat #(
    .DEBOUNCE_CYCLES     (DB),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .clk100_i(clk100_i),
    .rstn_i  (rstn_i),
    .kbd     (kbd)
  );

  always #5 clk100_i = ~clk100_i;

  // cyc equals the index of the most recent rising edge when read at a negedge.
  always @(posedge clk100_i) cyc <= cyc + 1;

  always @(negedge clk100_i) begin
    if (kbd.press_o || kbd.repeat_o || kbd.release_o) begin
      if (kbd.repeat_o) rep_seen++;
      vectors_applied++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL strobe_unexpected cyc=%0d got press=%b repeat=%b release=%b required no strobe",
                 cyc, kbd.press_o, kbd.repeat_o, kbd.release_o);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.cyc != cyc || mon_ev.press != kbd.press_o ||
            mon_ev.rpt != kbd.repeat_o || mon_ev.rel != kbd.release_o) begin
          miscompares++;
          $display("[TB] FAIL strobe_event got cyc=%0d p=%b r=%b rl=%b required cyc=%0d p=%b r=%b rl=%b",
                   cyc, kbd.press_o, kbd.repeat_o, kbd.release_o,
                   mon_ev.cyc, mon_ev.press, mon_ev.rpt, mon_ev.rel);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc=%0d required finish", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic void push_ev(int t, bit p, bit r, bit rl);
    ev_t e;
    e.cyc   = t;
    e.press = p;
    e.rpt   = r;
    e.rel   = rl;
    exp_q.push_back(e);
  endfunction

  // Timing model: key low sampled at edges e0..e0+low_len-1, high afterwards.
  function automatic void push_scenario(int e0, int low_len, bit rep_en);
    int rel_t;
    if (low_len < DB + 1) return;
    rel_t = e0 + low_len + DB + 2;
    push_ev(e0 + DB + 2, 1'b1, 1'b0, 1'b0);
    if (rep_en) begin
      for (int t = e0 + DB + 2 + RD; t < rel_t; t += RP) push_ev(t, 1'b1, 1'b1, 1'b0);
    end
    push_ev(rel_t, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic required);
    vectors_applied++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got %b required %b", name, cyc, actual, required);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int required);
    vectors_applied++;
    if (actual != required) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d required %0d", name, actual, required);
    end
  endtask

  task automatic checkDrained(input string name);
    vectors_applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d strobes missing required 0 (next due cyc=%0d)",
               name, exp_q.size(), exp_q[0].cyc);
    end
    exp_q.delete();
  endtask

  task automatic checkAllLow(input string name);
    checkOutput({name, "_held"},    kbd.held_o,    1'b0);
    checkOutput({name, "_press"},   kbd.press_o,   1'b0);
    checkOutput({name, "_repeat"},  kbd.repeat_o,  1'b0);
    checkOutput({name, "_release"}, kbd.release_o, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int e0;
    @(negedge clk100_i);
    kbd.repeat_en_i = v.rep_en;
    kbd.key_i       = 1'b0;
    rep_seen        = 0;
    e0              = cyc + 1;
    push_scenario(e0, v.low_len, v.rep_en);
    for (int i = 0; i < v.low_len + DB + 16; i++) begin
      @(negedge clk100_i);
      if (cyc == e0 + v.low_len - 1) kbd.key_i = 1'b1;
      if (cyc == e0 + DB + 3) checkOutput("held_mid", kbd.held_o, v.exp_pressed);
    end
    checkOutput("held_after", kbd.held_o, 1'b0);
    checkDrained("vector_strobes");
    checkCount("vector_repeats", rep_seen, v.exp_repeats);
  endtask

  initial begin
    int e0;

    vecs[0] = '{low_len: 3,  rep_en: 1'b1, exp_pressed: 1'b0, exp_repeats: 0};
    vecs[1] = '{low_len: 1,  rep_en: 1'b0, exp_pressed: 1'b0, exp_repeats: 0};
    vecs[2] = '{low_len: 8,  rep_en: 1'b1, exp_pressed: 1'b1, exp_repeats: 0};
    vecs[3] = '{low_len: 60, rep_en: 1'b0, exp_pressed: 1'b1, exp_repeats: 0};
    vecs[4] = '{low_len: 20, rep_en: 1'b1, exp_pressed: 1'b1, exp_repeats: 4};
    vecs[5] = '{low_len: 10, rep_en: 1'b1, exp_pressed: 1'b1, exp_repeats: 0};
    vecs[6] = '{low_len: 11, rep_en: 1'b1, exp_pressed: 1'b1, exp_repeats: 1};
    vecs[7] = '{low_len: 30, rep_en: 1'b1, exp_pressed: 1'b1, exp_repeats: 7};

    rstn_i          = 1'b0;
    kbd.key_i       = 1'b1;
    kbd.repeat_en_i = 1'b0;
    repeat (3) @(negedge clk100_i);
    checkAllLow("reset_state");
    rstn_i = 1'b1;
    repeat (5) @(negedge clk100_i);
    checkAllLow("idle_after_reset");

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset while a repeat strobe is high, with the key still held through release.
    @(negedge clk100_i);
    kbd.repeat_en_i = 1'b1;
    kbd.key_i       = 1'b0;
    e0              = cyc + 1;
    push_ev(e0 + DB + 2, 1'b1, 1'b0, 1'b0);
    push_ev(e0 + DB + 2 + RD, 1'b1, 1'b1, 1'b0);
    repeat (16) @(negedge clk100_i);
    @(posedge clk100_i);
    #1;
    checkOutput("repeat_before_reset", kbd.repeat_o, 1'b1);
    checkOutput("held_before_reset", kbd.held_o, 1'b1);
    #1;
    rstn_i = 1'b0;
    exp_q.delete();
    #1;
    checkAllLow("async_reset");
    repeat (3) @(negedge clk100_i);
    checkAllLow("during_reset");
    rstn_i = 1'b1;
    e0     = cyc + 1;
    push_scenario(e0, 18, 1'b1);
    rep_seen = 0;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk100_i);
      if (cyc == e0 + 17) kbd.key_i = 1'b1;
      if (cyc == e0 + DB + 3) checkOutput("held_after_reset_press", kbd.held_o, 1'b1);
    end
    checkDrained("reset_restart_strobes");
    checkCount("reset_restart_repeats", rep_seen, 3);

    // One-cycle repeat_en drop in REPEAT restarts the full delay.
    @(negedge clk100_i);
    kbd.repeat_en_i = 1'b1;
    kbd.key_i       = 1'b0;
    e0              = cyc + 1;
    push_ev(e0 + 6,  1'b1, 1'b0, 1'b0);
    push_ev(e0 + 16, 1'b1, 1'b1, 1'b0);
    push_ev(e0 + 19, 1'b1, 1'b1, 1'b0);
    push_ev(e0 + 30, 1'b1, 1'b1, 1'b0);
    push_ev(e0 + 33, 1'b1, 1'b1, 1'b0);
    push_ev(e0 + 36, 1'b1, 1'b1, 1'b0);
    push_ev(e0 + 38, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk100_i);
      if (cyc == e0 + 19) kbd.repeat_en_i = 1'b0;
      if (cyc == e0 + 20) kbd.repeat_en_i = 1'b1;
      if (cyc == e0 + 31) kbd.key_i = 1'b1;
    end
    checkDrained("enable_drop_strobes");
    checkAllLow("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
